// File: rtl/grover_measure.sv
// Readout stage for grover_search: snapshots the final amplitude vector, streams amp^2
// probabilities one per handshake and reports the most probable index and the probability sum.
module grover_measure #(
    parameter int num_bit        = 10,
    parameter int fixedpoint_bit = 24,
    parameter int num_sample     = 2**num_bit
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [fixedpoint_bit-1:0]   amp_in [0:num_sample-1],
    input  logic                               amp_done,
    output logic [fixedpoint_bit-1:0]          prob_out,
    output logic [num_bit-1:0]                 prob_idx,
    output logic                               prob_valid,
    input  logic                               prob_ready,
    output logic                               prob_last,
    output logic                               result_valid,
    output logic [num_bit-1:0]                 meas_idx,
    output logic [fixedpoint_bit-1:0]          meas_prob,
    output logic [fixedpoint_bit+num_bit-1:0]  prob_sum,
    input  logic                               result_ack
);

    localparam int fb = fixedpoint_bit;
    localparam int sw = fixedpoint_bit + num_bit;
    localparam logic [num_bit-1:0]     last_idx  = num_bit'(num_sample - 1);
    localparam logic signed [2*fb-1:0] sat_limit = {3'b001, {(2*fb-3){1'b0}}};
    localparam logic [fb-1:0]          sat_prob  = {1'b0, {(fb-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic                  amp_done_q;
    logic                  start;
    logic                  accept;
    logic signed [fb-1:0]  snapshot [0:num_sample-1];
    logic [num_bit-1:0]    idx;
    logic [fb-1:0]         max_prob;
    logic [num_bit-1:0]    max_idx;
    logic [sw-1:0]         sum;
    logic signed [fb-1:0]  cur_amp;
    logic signed [2*fb-1:0] amp_ext;
    logic signed [2*fb-1:0] product;
    logic [fb-1:0]         cur_prob;

    assign start   = amp_done & ~amp_done_q;
    assign accept  = (state == SCAN) & prob_ready;
    assign cur_amp = snapshot[idx];
    assign amp_ext = cur_amp;
    assign product = amp_ext * amp_ext;
    // Squares at or above 2.0 cannot be represented in Q1.(fb-2); clamp to the largest value.
    assign cur_prob = (product >= sat_limit) ? sat_prob : product[2*fb-3:fb-2];

    assign meas_idx  = max_idx;
    assign meas_prob = max_prob;
    assign prob_sum  = sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        prob_valid   = 1'b0;
        prob_out     = '0;
        prob_idx     = '0;
        prob_last    = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                prob_valid = 1'b1;
                prob_out   = cur_prob;
                prob_idx   = idx;
                prob_last  = (idx == last_idx);
                if (prob_ready && prob_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Max search uses strict greater-than so equal probabilities keep the lowest index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            amp_done_q <= 1'b0;
            idx        <= '0;
            max_prob   <= '0;
            max_idx    <= '0;
            sum        <= '0;
            for (int i = 0; i < num_sample; i++) begin
                snapshot[i] <= '0;
            end
        end else begin
            amp_done_q <= amp_done;
            if (state == IDLE && start) begin
                snapshot <= amp_in;
                idx      <= '0;
                max_prob <= '0;
                max_idx  <= '0;
                sum      <= '0;
            end else if (accept) begin
                sum <= sum + {{num_bit{1'b0}}, cur_prob};
                if (cur_prob > max_prob) begin
                    max_prob <= cur_prob;
                    max_idx  <= idx;
                end
                if (idx != last_idx) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule
